// File: rtl/design_18_pkg.sv
// Shared widths and helpers for the design_18 result path.
package design_18_pkg;

    localparam int W_DEF     = 16;
    localparam int CNT_W_DEF = 8;
    localparam logic [CNT_W_DEF-1:0] DROP_SAT = '1;

    function automatic int clog2_f(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < v) r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/design_18_sat_cnt.sv
// Saturating up-counter; a clear in the same cycle as an increment yields 1.
module design_18_sat_cnt #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = clr ? '0 : cnt_q;
        if (inc && (cnt_d != {CNT_W{1'b1}})) cnt_d = cnt_d + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/design_18_result_q.sv
// Result FIFO behind design_18: no input backpressure, overflowing results are
// dropped and counted.
module design_18_result_q
    import design_18_pkg::*;
#(
    parameter int W     = W_DEF,
    parameter int DEPTH = 4,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    input  logic [W-1:0]             in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [W-1:0]             out_data,
    output logic [clog2_f(DEPTH):0]  level,
    output logic                     full,
    output logic                     empty,
    output logic                     ovf,
    output logic [CNT_W-1:0]         drop_cnt,
    input  logic                     clr_ovf
);

    localparam int AW = clog2_f(DEPTH);

    logic [AW:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [W-1:0] mem_q [DEPTH];
    logic         ovf_q, ovf_d;
    logic         push, pop, drop;

    // Extra pointer MSB separates full from empty when the index bits match.
    assign empty     = (rd_ptr_q == wr_ptr_q);
    assign full      = (rd_ptr_q[AW] != wr_ptr_q[AW]) &&
                       (rd_ptr_q[AW-1:0] == wr_ptr_q[AW-1:0]);
    assign out_valid = !empty;
    assign level     = wr_ptr_q - rd_ptr_q;
    assign out_data  = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    assign pop  = out_valid & out_ready;
    assign push = in_valid & (!full | pop);
    assign drop = in_valid & full & !pop;

    always_comb begin
        rd_ptr_d = rd_ptr_q + (AW+1)'(pop);
        wr_ptr_d = wr_ptr_q + (AW+1)'(push);
        ovf_d    = clr_ovf ? 1'b0 : ovf_q;
        if (drop) ovf_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= in_data;
    end

    design_18_sat_cnt #(.CNT_W(CNT_W)) u_drop_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr_ovf),
        .inc   (drop),
        .cnt   (drop_cnt)
    );

    assign ovf = ovf_q;

endmodule

// File: tb/tb_design_18_result_q.sv
// Bench for design_18_result_q: directed table, hand sequences and random
// traffic against a queue-based reference model.
module tb_design_18_result_q;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] in_data = '0;
    logic        out_ready = 1'b0;
    logic        clr_ovf = 1'b0;

    logic        a_out_valid, a_full, a_empty, a_ovf;
    logic [15:0] a_out_data;
    logic [2:0]  a_level;
    logic [7:0]  a_drop_cnt;

    logic        b_out_valid, b_full, b_empty, b_ovf;
    logic [15:0] b_out_data;
    logic [2:0]  b_level;
    logic [1:0]  b_drop_cnt;

    always #5 clk = ~clk;

    design_18_result_q #(.W(16), .DEPTH(4), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .out_valid(a_out_valid), .out_ready(out_ready), .out_data(a_out_data),
        .level(a_level), .full(a_full), .empty(a_empty), .ovf(a_ovf),
        .drop_cnt(a_drop_cnt), .clr_ovf(clr_ovf)
    );

    design_18_result_q #(.W(16), .DEPTH(4), .CNT_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .out_valid(b_out_valid), .out_ready(out_ready), .out_data(b_out_data),
        .level(b_level), .full(b_full), .empty(b_empty), .ovf(b_ovf),
        .drop_cnt(b_drop_cnt), .clr_ovf(clr_ovf)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: a plain queue plus drop bookkeeping.
    logic [15:0] mq[$];
    bit          m_ovf;
    int          m_cnt_a, m_cnt_b;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_ovf   = 0;
        m_cnt_a = 0;
        m_cnt_b = 0;
    endtask

    task automatic model_edge();
        bit pop, push, drop, was_full;
        if (!rst_n) begin
            model_reset();
            return;
        end
        was_full = (mq.size() == 4);
        pop  = (mq.size() > 0) && out_ready;
        push = in_valid && (!was_full || pop);
        drop = in_valid && was_full && !pop;
        if (pop)  void'(mq.pop_front());
        if (push) mq.push_back(in_data);
        if (clr_ovf) begin
            m_ovf = 0; m_cnt_a = 0; m_cnt_b = 0;
        end
        if (drop) begin
            m_ovf = 1;
            if (m_cnt_a < 255) m_cnt_a++;
            if (m_cnt_b < 3)   m_cnt_b++;
        end
    endtask

    task automatic compare_model(input string tag);
        chk({tag, ".out_valid"}, a_out_valid, mq.size() > 0);
        chk({tag, ".out_data"},  a_out_data, (mq.size() > 0) ? mq[0] : 16'h0);
        chk({tag, ".level"},     a_level, mq.size());
        chk({tag, ".full"},      a_full, mq.size() == 4);
        chk({tag, ".empty"},     a_empty, mq.size() == 0);
        chk({tag, ".ovf"},       a_ovf, m_ovf);
        chk({tag, ".drop_cnt"},  a_drop_cnt, m_cnt_a);
        chk({tag, ".b_drop_cnt"}, b_drop_cnt, m_cnt_b);
        chk({tag, ".b_level"},   b_level, mq.size());
    endtask

    task automatic cycle(input string tag);
        model_edge();
        @(posedge clk);
        #1;
        compare_model(tag);
    endtask

    task automatic drive(input bit iv, input logic [15:0] d, input bit rdy, input bit clr);
        in_valid  = iv;
        in_data   = d;
        out_ready = rdy;
        clr_ovf   = clr;
    endtask

    typedef struct {
        bit          iv;
        logic [15:0] d;
        bit          rdy;
        bit          clr;
        int          lvl;
        logic [15:0] head;
        bit          ovf;
        int          cnt;
    } vec_t;

    vec_t vecs[15];

    function automatic vec_t mk(bit iv, logic [15:0] d, bit rdy, bit clr,
                                int lvl, logic [15:0] head, bit ovf, int cnt);
        vec_t v;
        v.iv = iv; v.d = d; v.rdy = rdy; v.clr = clr;
        v.lvl = lvl; v.head = head; v.ovf = ovf; v.cnt = cnt;
        return v;
    endfunction

    initial begin
        vecs[0]  = mk(1, 16'h0001, 0, 0, 1, 16'h0001, 0, 0);
        vecs[1]  = mk(1, 16'h0002, 0, 0, 2, 16'h0001, 0, 0);
        vecs[2]  = mk(1, 16'h0003, 0, 0, 3, 16'h0001, 0, 0);
        vecs[3]  = mk(1, 16'h0004, 0, 0, 4, 16'h0001, 0, 0);
        vecs[4]  = mk(0, 16'h0000, 1, 0, 3, 16'h0002, 0, 0);
        vecs[5]  = mk(0, 16'h0000, 1, 0, 2, 16'h0003, 0, 0);
        vecs[6]  = mk(0, 16'h0000, 1, 0, 1, 16'h0004, 0, 0);
        vecs[7]  = mk(0, 16'h0000, 1, 0, 0, 16'h0000, 0, 0);
        vecs[8]  = mk(1, 16'h0001, 0, 0, 1, 16'h0001, 0, 0);
        vecs[9]  = mk(1, 16'h0002, 0, 0, 2, 16'h0001, 0, 0);
        vecs[10] = mk(1, 16'h0003, 0, 0, 3, 16'h0001, 0, 0);
        vecs[11] = mk(1, 16'h0004, 0, 0, 4, 16'h0001, 0, 0);
        vecs[12] = mk(1, 16'h0005, 0, 0, 4, 16'h0001, 1, 1); // dropped
        vecs[13] = mk(1, 16'h0006, 1, 0, 4, 16'h0002, 1, 1); // pop+push while full
        vecs[14] = mk(0, 16'h0000, 0, 1, 4, 16'h0002, 0, 0);

        model_reset();

        // Reset held with a live strobe: nothing may be captured.
        drive(1, 16'hAAAA, 0, 0);
        repeat (3) cycle("rst");
        chk("rst.out_valid", a_out_valid, 0);
        chk("rst.empty", a_empty, 1);
        chk("rst.out_data", a_out_data, 0);
        drive(0, 16'h0000, 0, 0);
        rst_n = 1'b1;
        cycle("rst_rel");

        // Directed table.
        for (int i = 0; i < 15; i++) begin
            drive(vecs[i].iv, vecs[i].d, vecs[i].rdy, vecs[i].clr);
            cycle("tbl");
            chk($sformatf("tbl[%0d].level", i), a_level, vecs[i].lvl);
            chk($sformatf("tbl[%0d].out_data", i), a_out_data, vecs[i].head);
            chk($sformatf("tbl[%0d].ovf", i), a_ovf, vecs[i].ovf);
            chk($sformatf("tbl[%0d].drop_cnt", i), a_drop_cnt, vecs[i].cnt);
            chk($sformatf("tbl[%0d].full", i), a_full, vecs[i].lvl == 4);
        end

        // Saturation of the 2-bit counter, then clear priority (queue is full here).
        begin
            int exp_b[5] = '{1, 2, 3, 3, 3};
            for (int i = 0; i < 5; i++) begin
                drive(1, 16'h0100 + 16'(i), 0, 0);
                cycle("sat");
                chk($sformatf("sat[%0d].b_drop_cnt", i), b_drop_cnt, exp_b[i]);
                chk($sformatf("sat[%0d].drop_cnt", i), a_drop_cnt, i + 1);
            end
        end
        drive(1, 16'h0200, 0, 1);
        cycle("clr_drop");
        chk("clr_drop.ovf", a_ovf, 1);
        chk("clr_drop.b_drop_cnt", b_drop_cnt, 1);
        chk("clr_drop.drop_cnt", a_drop_cnt, 1);
        drive(0, 16'h0000, 0, 1);
        cycle("clr_only");
        chk("clr_only.ovf", a_ovf, 0);
        chk("clr_only.drop_cnt", a_drop_cnt, 0);
        chk("clr_only.b_drop_cnt", b_drop_cnt, 0);

        // Drain, refill to 3, then asynchronous reset between edges.
        drive(0, 16'h0000, 1, 0);
        repeat (4) cycle("drain");
        for (int i = 0; i < 3; i++) begin
            drive(1, 16'h0300 + 16'(i), 0, 0);
            cycle("fill3");
        end
        chk("fill3.level", a_level, 3);
        drive(0, 16'h0000, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst.out_valid", a_out_valid, 0);
        chk("arst.level", a_level, 0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(1, 16'h00FF, 0, 0);
        cycle("after_rst");
        chk("after_rst.out_data", a_out_data, 16'h00FF);
        chk("after_rst.level", a_level, 1);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 3) != 0), 16'($urandom()),
                  ($urandom_range(0, 2) == 0), ($urandom_range(0, 19) == 0));
            cycle("rnd");
        end

        drive(0, 16'h0000, 0, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
